sobel_frame_ctrl: RTL and testbench

Frame sequencer for the Sobel window datapath: accepts one 8-bit pixel stream per frame, generates the per-pixel shift enable for the two line buffers and the 3x3 window register, then injects zero flush pixels so the final row's windows complete. Reports each completed window's centre position and a border tap mask. Sits between the pixel source and the line-buffer/window stage, and replaces the window stage's local fill counter as the frame authority.

---
 rtl/sobel_pkg.sv | 41 ++++
 rtl/sobel_frame_ctrl_if.sv | 33 +++
 rtl/sobel_win_pos.sv | 63 ++++++
 rtl/sobel_frame_ctrl.sv | 103 ++++++++++
 tb/tb_sobel_frame_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame controller: FSM states,
// 3x3 tap indices (row-major d0..d8) and the per-edge tap groups.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int TAP_D0 = 0;
  localparam int TAP_D1 = 1;
  localparam int TAP_D2 = 2;
  localparam int TAP_D3 = 3;
  localparam int TAP_D4 = 4;
  localparam int TAP_D5 = 5;
  localparam int TAP_D6 = 6;
  localparam int TAP_D7 = 7;
  localparam int TAP_D8 = 8;

  localparam logic [8:0] TAP_ALL = 9'h1FF;

  // Taps lying outside the frame when the centre sits on the given edge.
  localparam logic [8:0] EDGE_TOP    = (9'd1 << TAP_D0) | (9'd1 << TAP_D1) | (9'd1 << TAP_D2);
  localparam logic [8:0] EDGE_BOTTOM = (9'd1 << TAP_D6) | (9'd1 << TAP_D7) | (9'd1 << TAP_D8);
  localparam logic [8:0] EDGE_LEFT   = (9'd1 << TAP_D0) | (9'd1 << TAP_D3) | (9'd1 << TAP_D6);
  localparam logic [8:0] EDGE_RIGHT  = (9'd1 << TAP_D2) | (9'd1 << TAP_D5) | (9'd1 << TAP_D8);

  function automatic logic [8:0] border_mask(input logic top, input logic bottom,
                                             input logic left, input logic right);
    logic [8:0] m;
    m = TAP_ALL;
    if (top)    m = m & ~EDGE_TOP;
    if (bottom) m = m & ~EDGE_BOTTOM;
    if (left)   m = m & ~EDGE_LEFT;
    if (right)  m = m & ~EDGE_RIGHT;
    return m;
  endfunction

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Handshake/bus bundle between the pixel source, the Sobel frame controller
// and the line-buffer/window datapath.
interface sobel_frame_ctrl_if #(
  parameter int RW = 7,
  parameter int CW = 7
);
  logic          start_i;
  logic          busy_o;
  logic          dp_clr_o;
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic [7:0]    pix_data_i;
  logic          stall_i;
  logic          shift_o;
  logic [7:0]    shift_data_o;
  logic          win_valid_o;
  logic [RW-1:0] win_row_o;
  logic [CW-1:0] win_col_o;
  logic [8:0]    tap_mask_o;
  logic          frame_done_o;

  modport master (
    output start_i, pix_valid_i, pix_data_i, stall_i,
    input  busy_o, dp_clr_o, pix_ready_o, shift_o, shift_data_o,
           win_valid_o, win_row_o, win_col_o, tap_mask_o, frame_done_o
  );

  modport slave (
    input  start_i, pix_valid_i, pix_data_i, stall_i,
    output busy_o, dp_clr_o, pix_ready_o, shift_o, shift_data_o,
           win_valid_o, win_row_o, win_col_o, tap_mask_o, frame_done_o
  );
endinterface

// File: rtl/sobel_win_pos.sv
// Window centre position counters and tap-mask decode, advanced once per
// window-completing shift. Border masking when SOBEL_CTRL_BORDER_MASK_EN is defined.
module sobel_win_pos
  import sobel_pkg::*;
#(
  parameter int ROWS = 128,
  parameter int COLS = 128,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic          win_valid,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic [8:0]    tap_mask
);

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [8:0]    mask_d;

  always_comb begin
`ifdef SOBEL_CTRL_BORDER_MASK_EN
    mask_d = border_mask(row_q == '0, row_q == RW'(ROWS - 1),
                         col_q == '0, col_q == CW'(COLS - 1));
`else
    mask_d = TAP_ALL;
`endif
  end

  // NOTE: every flop here is reset, including the output registers, so a
  // mid-frame reset drives the window outputs to 0 immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q     <= '0;
      col_q     <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      tap_mask  <= '0;
    end else begin
      win_valid <= adv;
      tap_mask  <= adv ? mask_d : '0;
      if (clr) begin
        row_q <= '0;
        col_q <= '0;
      end else if (adv) begin
        win_row <= row_q;
        win_col <= col_q;
        if (col_q == CW'(COLS - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Sobel frame sequencer: accepts one pixel frame, drives datapath shifts,
// injects COLS+1 zero flush pixels, reports window positions. Option macro:
// SOBEL_CTRL_BORDER_MASK_EN (border-aware tap mask).
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int ROWS = 128,
  parameter int COLS = 128,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  sobel_frame_ctrl_if.slave bus
);

  localparam int NPIX   = ROWS * COLS;
  localparam int NSHIFT = NPIX + COLS + 1;
  localparam int KW     = $clog2(NSHIFT + 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q;
  logic          shift, pix_ready, dp_clr, busy, frame_done;
  logic [7:0]    shift_data;
  logic          win_adv;

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pix_ready  = 1'b0;
    shift      = 1'b0;
    shift_data = '0;
    dp_clr     = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          dp_clr  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy       = 1'b1;
        pix_ready  = !bus.stall_i;
        shift      = bus.pix_valid_i && !bus.stall_i;
        shift_data = bus.pix_data_i;
        if (shift && k_q == KW'(NPIX - 1)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy  = 1'b1;
        shift = !bus.stall_i;
        if (shift && k_q == KW'(NSHIFT - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      if (dp_clr)     k_q <= '0;
      else if (shift) k_q <= k_q + 1'b1;
    end
  end

  // Shift k completes the window centred COLS+1 pixels behind it.
  assign win_adv = shift && (k_q >= KW'(COLS + 1));

  sobel_win_pos #(
    .ROWS(ROWS),
    .COLS(COLS),
    .RW  (RW),
    .CW  (CW)
  ) u_win_pos (
    .clk      (clk),
    .rst      (rst),
    .clr      (dp_clr),
    .adv      (win_adv),
    .win_valid(bus.win_valid_o),
    .win_row  (bus.win_row_o),
    .win_col  (bus.win_col_o),
    .tap_mask (bus.tap_mask_o)
  );

  assign bus.busy_o       = busy;
  assign bus.dp_clr_o     = dp_clr;
  assign bus.pix_ready_o  = pix_ready;
  assign bus.shift_o      = shift;
  assign bus.shift_data_o = shift_data;
  assign bus.frame_done_o = frame_done;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed self-checking bench for sobel_frame_ctrl at ROWS=5, COLS=6.
module tb_sobel_frame_ctrl;

  localparam int ROWS   = 5;
  localparam int COLS   = 6;
  localparam int RW     = 3;
  localparam int CW     = 3;
  localparam int NPIX   = 30;
  localparam int NSHIFT = 37;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_frame_ctrl_if #(.RW(RW), .CW(CW)) bus ();

  sobel_frame_ctrl #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Hand-derived masks: (0,0)=1B0, (0,5)=0D8, (2,2)=1FF, (4,5)=01B with the option.
  function automatic logic [8:0] exp_mask(input int r, input int c);
    logic [8:0] m;
    m = 9'h1FF;
`ifdef SOBEL_CTRL_BORDER_MASK_EN
    if (r == 0)        m[2:0] = 3'b000;
    if (r == ROWS - 1) m[8:6] = 3'b000;
    if (c == 0)        begin m[0] = 1'b0; m[3] = 1'b0; m[6] = 1'b0; end
    if (c == COLS - 1) begin m[2] = 1'b0; m[5] = 1'b0; m[8] = 1'b0; end
`endif
    return m;
  endfunction

  int shift_cnt, win_cnt, acc_cnt, clr_cnt, exp_r, exp_c;
  bit saw_done;

  always @(negedge clk) begin
    if (!rst) begin
      bit last;
      last = (exp_r == ROWS - 1) && (exp_c == COLS - 1);
      if (bus.win_valid_o || bus.frame_done_o)
        check("done_align", bus.frame_done_o, bus.win_valid_o && last);
      if (bus.win_valid_o) begin
        if (win_cnt == 0) check("first_win_lat", shift_cnt, 8);
        check("win_row", bus.win_row_o, exp_r);
        check("win_col", bus.win_col_o, exp_c);
        check("tap_mask", bus.tap_mask_o, exp_mask(exp_r, exp_c));
        win_cnt++;
        if (exp_c == COLS - 1) begin
          exp_c = 0;
          exp_r = (exp_r == ROWS - 1) ? 0 : exp_r + 1;
        end else begin
          exp_c++;
        end
      end else if (bus.tap_mask_o !== 9'h000) begin
        check("mask_no_win", bus.tap_mask_o, 0);
      end
      if (bus.stall_i) check("shift_stall", bus.shift_o, 0);
      if (bus.pix_valid_i && bus.pix_ready_o) acc_cnt++;
      if (bus.busy_o && shift_cnt >= NPIX) check("flush_ready", bus.pix_ready_o, 0);
      if (bus.shift_o) begin
        if (shift_cnt < NPIX) check("run_data", bus.shift_data_o, bus.pix_data_i);
        else                  check("flush_data", bus.shift_data_o, 0);
        shift_cnt++;
      end
      if (bus.frame_done_o) saw_done = 1'b1;
      if (bus.dp_clr_o) clr_cnt++;
    end
  end

  task automatic start_frame();
    @(posedge clk); #1;
    shift_cnt = 0; win_cnt = 0; acc_cnt = 0; clr_cnt = 0;
    exp_r = 0; exp_c = 0; saw_done = 1'b0;
    bus.start_i = 1'b1; bus.pix_valid_i = 1'b0; bus.stall_i = 1'b0;
    #1 check("dp_clr_start", bus.dp_clr_o, 1);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check("busy_run", bus.busy_o, 1);
    check("dp_clr_one_cycle", bus.dp_clr_o, 0);
  endtask

  task automatic run_frame(input int gap_pct, input bit poke_start);
    int cyc;
    start_frame();
    cyc = 0;
    while (!saw_done && cyc < BUDGET) begin
      bus.pix_valid_i = ($urandom_range(99) >= gap_pct);
      bus.stall_i     = (gap_pct != 0) && ($urandom_range(99) < gap_pct);
      bus.pix_data_i  = 8'($urandom);
      bus.start_i     = poke_start && (cyc == 10);
      if (bus.start_i) begin
        #1 check("start_in_run_clr", bus.dp_clr_o, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start_i = 1'b0; bus.pix_valid_i = 1'b0; bus.stall_i = 1'b0;
    check("frame_in_budget", cyc < BUDGET, 1);
    check("shift_total", shift_cnt, NSHIFT);
    check("win_total", win_cnt, NPIX);
    check("accept_total", acc_cnt, NPIX);
    check("clr_total", clr_cnt, 1);
    check("idle_after_done", bus.busy_o, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.pix_valid_i = 1'b0; bus.pix_data_i = 8'h00; bus.stall_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy_o, 0);
    check("rst_win_valid", bus.win_valid_o, 0);
    check("rst_tap_mask", bus.tap_mask_o, 0);
    check("rst_frame_done", bus.frame_done_o, 0);
    check("rst_win_pos", {bus.win_row_o, bus.win_col_o}, 0);
    rst = 1'b0;

    // Idle with valid and stall asserted: nothing is consumed or shifted.
    bus.pix_valid_i = 1'b1; bus.stall_i = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", bus.pix_ready_o, 0);
    check("idle_shift", bus.shift_o, 0);
    bus.stall_i = 1'b0;
    #1 check("idle_shift_nostall", bus.shift_o, 0);
    bus.pix_valid_i = 1'b0;

    run_frame(0, 1'b0);

    // Valid held after the frame: controller stays idle and unready.
    bus.pix_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_ready", bus.pix_ready_o, 0);
      check("post_shift", bus.shift_o, 0);
    end
    bus.pix_valid_i = 1'b0;

    run_frame(30, 1'b1);
    run_frame(0, 1'b0);

    // Reset asserted while flushing.
    start_frame();
    bus.pix_valid_i = 1'b1;
    cyc = 0;
    while (shift_cnt < NPIX + 2 && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_flush", cyc < BUDGET, 1);
    check("in_flush_busy", bus.busy_o, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_shift", bus.shift_o, 0);
    check("mid_rst_ready", bus.pix_ready_o, 0);
    check("mid_rst_data", bus.shift_data_o, 0);
    check("mid_rst_win", bus.win_valid_o, 0);
    check("mid_rst_pos", {bus.win_row_o, bus.win_col_o}, 0);
    check("mid_rst_mask", bus.tap_mask_o, 0);
    check("mid_rst_done", bus.frame_done_o, 0);
    bus.pix_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(20, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
